adma_sequencer: RTL and testbench

ADMA2 sequencer for the SD host DMA path. It walks the descriptor table in system memory, decodes each descriptor, and issues one transfer command per data descriptor to the existing transfer engine. It sits between the host command/control registers (start, continue, stop, direction, table base) and two memory-side ports: a descriptor read port and the transfer engine command port.

---
 rtl/adma_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_adma_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adma_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adma_sequencer
// Brief    : ADMA2 descriptor-table walker that issues one transfer command per
//            data descriptor. ADMA_ADDR64_EN selects 128-bit two-beat descriptors.
// Revision : 1.0  initial release
// ============================================================================
module adma_sequencer #(
    parameter int DESC_ABITS = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STOP,
    input  logic        command_reg_write,
    input  logic        command_reg_continue,
    input  logic        direction,
    input  logic [63:0] starting_address,
    output logic        desc_req,
    output logic [63:0] desc_addr,
    input  logic        desc_ack,
    input  logic [63:0] desc_data,
    input  logic        desc_err,
    output logic        xfer_start,
    output logic [63:0] xfer_addr,
    output logic [16:0] xfer_len,
    output logic        xfer_dir,
    input  logic        xfer_done,
    input  logic        xfer_err,
    output logic        busy,
    output logic        int_pulse,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_state,
    output logic [63:0] err_addr
);

`ifdef ADMA_ADDR64_EN
    // 128-bit descriptors always advance by 16 bytes regardless of the parameter
    localparam int c_abits = DESC_ABITS - DESC_ABITS + 4;
`else
    localparam int c_abits = DESC_ABITS;
`endif
    localparam logic [63:0] c_stride = 64'd1 << c_abits;
    localparam logic [63:0] c_mask   = ~(c_stride - 64'd1);

    localparam logic [2:0] ST_STOP  = 3'd0;
    localparam logic [2:0] ST_FDS   = 3'd1;
    localparam logic [2:0] ST_CADR  = 3'd2;
    localparam logic [2:0] ST_TFR   = 3'd3;
    localparam logic [2:0] ST_PAUSE = 3'd4;

    localparam logic [1:0] c_act_tran = 2'b10;
    localparam logic [1:0] c_act_link = 2'b11;

    logic [2:0]  r_state;
    logic [63:0] r_ptr;
    logic        r_dir;
    logic [2:0]  r_attr;       // {int, end, valid}
    logic [1:0]  r_act;
    logic [15:0] r_len;
    logic [63:0] r_desc_addr;
    logic [63:0] r_xfer_addr;
    logic [16:0] r_xfer_len;
    logic        r_xfer_start;
    logic        r_done;
    logic        r_int;
    logic        r_err;
    logic [1:0]  r_err_state;
    logic [63:0] r_err_addr;
`ifdef ADMA_ADDR64_EN
    logic        r_beat;
`endif

    logic [2:0]  w_cmpl_state;
    logic        w_unused;

    // END beats STOP; STOP only parks the walker between descriptors
    assign w_cmpl_state = r_attr[1] ? ST_STOP : (STOP ? ST_PAUSE : ST_FDS);
    assign w_unused     = &{1'b0, desc_data[15:6], desc_data[3]};

    assign desc_req   = (r_state == ST_FDS);
`ifdef ADMA_ADDR64_EN
    assign desc_addr  = r_ptr + (r_beat ? 64'd8 : 64'd0);
`else
    assign desc_addr  = r_ptr;
`endif
    assign xfer_start = r_xfer_start;
    assign xfer_addr  = r_xfer_addr;
    assign xfer_len   = r_xfer_len;
    assign xfer_dir   = r_dir;
    assign busy       = (r_state != ST_STOP);
    assign int_pulse  = r_int;
    assign done       = r_done;
    assign err        = r_err;
    assign err_state  = r_err_state;
    assign err_addr   = r_err_addr;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= ST_STOP;
            r_ptr        <= 64'd0;
            r_dir        <= 1'b0;
            r_attr       <= 3'd0;
            r_act        <= 2'd0;
            r_len        <= 16'd0;
            r_desc_addr  <= 64'd0;
            r_xfer_addr  <= 64'd0;
            r_xfer_len   <= 17'd0;
            r_xfer_start <= 1'b0;
            r_done       <= 1'b0;
            r_int        <= 1'b0;
            r_err        <= 1'b0;
            r_err_state  <= 2'b00;
            r_err_addr   <= 64'd0;
`ifdef ADMA_ADDR64_EN
            r_beat       <= 1'b0;
`endif
        end else begin
            r_xfer_start <= 1'b0;
            r_done       <= 1'b0;
            r_int        <= 1'b0;
            case (r_state)
                ST_STOP: begin
                    if (command_reg_write) begin
                        r_state <= ST_FDS;
                        r_ptr   <= starting_address & c_mask;
                        r_dir   <= direction;
                        r_err   <= 1'b0;
                    end
                end
                ST_FDS: begin
                    if (desc_ack) begin
                        if (desc_err) begin
                            r_err       <= 1'b1;
                            r_err_state <= 2'b01;
                            r_err_addr  <= r_ptr;
                            r_state     <= ST_STOP;
`ifdef ADMA_ADDR64_EN
                            r_beat      <= 1'b0;
                        end else if (!r_beat) begin
                            r_attr <= desc_data[2:0];
                            r_act  <= desc_data[5:4];
                            r_len  <= desc_data[31:16];
                            r_beat <= 1'b1;
                        end else begin
                            r_desc_addr <= desc_data;
                            r_beat      <= 1'b0;
                            r_state     <= ST_CADR;
                        end
`else
                        end else begin
                            r_attr      <= desc_data[2:0];
                            r_act       <= desc_data[5:4];
                            r_len       <= desc_data[31:16];
                            r_desc_addr <= {32'd0, desc_data[63:32]};
                            r_state     <= ST_CADR;
                        end
`endif
                    end
                end
                ST_CADR: begin
                    if (!r_attr[0]) begin
                        r_err       <= 1'b1;
                        r_err_state <= 2'b01;
                        r_err_addr  <= r_ptr;
                        r_state     <= ST_STOP;
                    end else if (r_act == c_act_tran) begin
                        r_state      <= ST_TFR;
                        r_xfer_start <= 1'b1;
                        r_xfer_addr  <= r_desc_addr;
                        // a zero length field encodes the full 64 KiB
                        r_xfer_len   <= {(r_len == 16'd0), r_len};
                    end else begin
                        if (r_act == c_act_link) begin
                            r_ptr <= r_desc_addr & c_mask;
                        end else begin
                            r_ptr <= r_ptr + c_stride;
                        end
                        r_int   <= r_attr[2];
                        r_done  <= r_attr[1];
                        r_state <= w_cmpl_state;
                    end
                end
                ST_TFR: begin
                    if (xfer_err) begin
                        r_err       <= 1'b1;
                        r_err_state <= 2'b11;
                        r_err_addr  <= r_ptr;
                        r_state     <= ST_STOP;
                    end else if (xfer_done) begin
                        r_ptr   <= r_ptr + c_stride;
                        r_int   <= r_attr[2];
                        r_done  <= r_attr[1];
                        r_state <= w_cmpl_state;
                    end
                end
                ST_PAUSE: begin
                    if (command_reg_continue && !STOP) begin
                        r_state <= ST_FDS;
                    end
                end
                default: r_state <= ST_STOP;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adma_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adma_sequencer
// Brief    : Scoreboard bench for adma_sequencer with descriptor memory and
//            transfer engine models. Honors ADMA_ADDR64_EN like the design.
// Revision : 1.0  initial release
// ============================================================================
module tb_adma_sequencer;

`ifdef ADMA_ADDR64_EN
    localparam logic [63:0] c_stride = 64'd16;
`else
    localparam logic [63:0] c_stride = 64'd8;
`endif

    typedef struct {
        logic [63:0] addr;
        logic [16:0] len;
        logic        dir;
    } xfer_t;

    logic        CLK;
    logic        RESET;
    logic        STOP;
    logic        command_reg_write;
    logic        command_reg_continue;
    logic        direction;
    logic [63:0] starting_address;
    logic        desc_req;
    logic [63:0] desc_addr;
    logic        desc_ack;
    logic [63:0] desc_data;
    logic        desc_err;
    logic        xfer_start;
    logic [63:0] xfer_addr;
    logic [16:0] xfer_len;
    logic        xfer_dir;
    logic        xfer_done;
    logic        xfer_err;
    logic        busy;
    logic        int_pulse;
    logic        done;
    logic        err;
    logic [1:0]  err_state;
    logic [63:0] err_addr;

    int          checks = 0;
    int          errors = 0;
    logic        stall = 1'b0;
    logic        err_mode = 1'b0;
    int          eng_cnt = 0;

    logic [63:0] mem [logic [63:0]];
    logic [63:0] exp_fetch [$];
    xfer_t       exp_xfer [$];
    logic [1:0]  exp_pulse [$];   // {done, int_pulse}

    adma_sequencer dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .STOP                 (STOP),
        .command_reg_write    (command_reg_write),
        .command_reg_continue (command_reg_continue),
        .direction            (direction),
        .starting_address     (starting_address),
        .desc_req             (desc_req),
        .desc_addr            (desc_addr),
        .desc_ack             (desc_ack),
        .desc_data            (desc_data),
        .desc_err             (desc_err),
        .xfer_start           (xfer_start),
        .xfer_addr            (xfer_addr),
        .xfer_len             (xfer_len),
        .xfer_dir             (xfer_dir),
        .xfer_done            (xfer_done),
        .xfer_err             (xfer_err),
        .busy                 (busy),
        .int_pulse            (int_pulse),
        .done                 (done),
        .err                  (err),
        .err_state            (err_state),
        .err_addr             (err_addr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [127:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=none", name, act);
    endtask

    // Descriptor memory: one-cycle ack, at most every other cycle
    always @(negedge CLK) begin
        desc_err = 1'b0;
        if (desc_req && !desc_ack && !stall) begin
            desc_ack  = 1'b1;
            desc_data = mem.exists(desc_addr) ? mem[desc_addr] : 64'd0;
        end else begin
            desc_ack  = 1'b0;
        end
    end

    // Transfer engine: completes three cycles after the command
    always @(negedge CLK) begin
        xfer_done = 1'b0;
        xfer_err  = 1'b0;
        if (RESET) begin
            eng_cnt = 0;
        end else if (xfer_start) begin
            eng_cnt = 3;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                xfer_done = 1'b1;
                xfer_err  = err_mode;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event
    always @(negedge CLK) begin
        #1;
        if (desc_req && desc_ack) begin
            if (exp_fetch.size() == 0) flag("unexpected_fetch", desc_addr);
            else chk("fetch_addr", desc_addr, exp_fetch.pop_front());
        end
        if (xfer_start) begin
            if (exp_xfer.size() == 0) begin
                flag("unexpected_xfer", xfer_addr);
            end else begin
                xfer_t e;
                e = exp_xfer.pop_front();
                chk("xfer_addr", xfer_addr, e.addr);
                chk("xfer_len", xfer_len, e.len);
                chk("xfer_dir", xfer_dir, e.dir);
            end
        end
        if (done || int_pulse) begin
            if (exp_pulse.size() == 0) flag("unexpected_pulse", {done, int_pulse});
            else chk("done_int", {done, int_pulse}, exp_pulse.pop_front());
        end
    end

    task automatic put_desc(input logic [63:0] p, input logic [31:0] lo, input logic [63:0] a);
`ifdef ADMA_ADDR64_EN
        mem[p]         = {32'd0, lo};
        mem[p + 64'd8] = a;
`else
        mem[p] = {a[31:0], lo};
`endif
    endtask

    task automatic exp_desc(input logic [63:0] p);
        exp_fetch.push_back(p);
`ifdef ADMA_ADDR64_EN
        exp_fetch.push_back(p + 64'd8);
`endif
    endtask

    task automatic exp_x(input logic [63:0] a, input logic [16:0] l, input logic d);
        xfer_t e;
        e.addr = a;
        e.len  = l;
        e.dir  = d;
        exp_xfer.push_back(e);
    endtask

    task automatic start(input logic [63:0] base, input logic d);
        starting_address  = base;
        direction         = d;
        command_reg_write = 1'b1;
        @(negedge CLK);
        command_reg_write = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (busy) flag({name, "_idle_timeout"}, busy);
        @(negedge CLK);
        #2;
        chk({name, "_scoreboard_left"}, exp_fetch.size() + exp_xfer.size() + exp_pulse.size(), 0);
    endtask

    task automatic wait_xfer(input string name);
        int n = 0;
        while (!xfer_start && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!xfer_start) flag({name, "_xfer_timeout"}, xfer_start);
    endtask

    initial begin
        RESET = 1'b1;
        STOP = 1'b0;
        command_reg_write = 1'b0;
        command_reg_continue = 1'b0;
        direction = 1'b0;
        starting_address = 64'd0;
        desc_ack = 1'b0;
        desc_data = 64'd0;
        desc_err = 1'b0;
        xfer_done = 1'b0;
        xfer_err = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_desc", {desc_req, desc_addr}, 0);
        chk("rst_xfer", {xfer_start, xfer_addr, xfer_len, xfer_dir}, 0);
        chk("rst_status", {int_pulse, done, err, err_state, err_addr}, 0);

        // Two transfers, second with END+INT and length 0 (64 KiB)
        mem.delete();
        put_desc(64'h1000, 32'h0200_0021, 64'h8000);
        put_desc(64'h1000 + c_stride, 32'h0000_0027, 64'h9000);
        exp_desc(64'h1000);
        exp_desc(64'h1000 + c_stride);
        exp_x(64'h8000, 17'h00200, 1'b1);
        exp_x(64'h9000, 17'h10000, 1'b1);
        exp_pulse.push_back(2'b11);
        start(64'h1000, 1'b1);
        chk("start_to_req", desc_req, 1);
        wait_xfer("t1");
        @(negedge CLK);
        start(64'h7000, 1'b0);   // ignored while busy
        wait_idle("t1");
        chk("t1_err", err, 0);

        // Link with unaligned target
        mem.delete();
        put_desc(64'h1000, 32'h0000_0031, 64'h2007);
        put_desc(64'h2000, 32'h0010_0023, 64'hA000);
        exp_desc(64'h1000);
        exp_desc(64'h2000);
        exp_x(64'hA000, 17'h00010, 1'b0);
        exp_pulse.push_back(2'b10);
        start(64'h1000, 1'b0);
        wait_idle("t2");

        // NOP with INT, then invalid descriptor
        mem.delete();
        put_desc(64'h1000, 32'h0000_0005, 64'h0);
        exp_desc(64'h1000);
        exp_desc(64'h1000 + c_stride);
        exp_pulse.push_back(2'b01);
        start(64'h1000, 1'b0);
        wait_idle("t3");
        chk("t3_err", {err, err_state}, {1'b1, 2'b01});
        chk("t3_err_addr", err_addr, 64'h1000 + c_stride);

        // STOP during the first transfer parks in PAUSE
        mem.delete();
        put_desc(64'h1000, 32'h0040_0021, 64'h3000);
        put_desc(64'h1000 + c_stride, 32'h0080_0023, 64'h4000);
        exp_desc(64'h1000);
        exp_x(64'h3000, 17'h00040, 1'b1);
        exp_x(64'h4000, 17'h00080, 1'b1);
        exp_pulse.push_back(2'b10);
        start(64'h1000, 1'b1);
        chk("t4_err_cleared", err, 0);
        wait_xfer("t4");
        STOP = 1'b1;
        repeat (10) @(negedge CLK);
        chk("t4_paused_busy", {busy, desc_req}, 2'b10);
        command_reg_continue = 1'b1;   // ignored while STOP is high
        @(negedge CLK);
        command_reg_continue = 1'b0;
        repeat (5) @(negedge CLK);
        chk("t4_still_paused", {busy, desc_req}, 2'b10);
        STOP = 1'b0;
        exp_desc(64'h1000 + c_stride);
        command_reg_continue = 1'b1;
        @(negedge CLK);
        command_reg_continue = 1'b0;
        wait_idle("t4");

        // xfer_err together with xfer_done: error wins, no done
        mem.delete();
        put_desc(64'h1000, 32'h0008_0027, 64'h5000);
        exp_desc(64'h1000);
        exp_x(64'h5000, 17'h00008, 1'b0);
        err_mode = 1'b1;
        start(64'h1000, 1'b0);
        wait_idle("t5");
        err_mode = 1'b0;
        chk("t5_err", {err, err_state}, {1'b1, 2'b11});
        chk("t5_err_addr", err_addr, 64'h1000);

        // RESET while fetching, then restart from a new base
        mem.delete();
        stall = 1'b1;
        start(64'h1000, 1'b1);
        repeat (2) @(negedge CLK);
        chk("t6_fetch_hold", {desc_req, desc_addr}, {1'b1, 64'h1000});
        RESET = 1'b1;
        @(negedge CLK);
        chk("t6_reset_outs", {desc_req, desc_addr, busy, err, err_state, xfer_start, done}, 0);
        RESET = 1'b0;
        stall = 1'b0;
        put_desc(64'h2000, 32'h0004_0023, 64'h6000);
        exp_desc(64'h2000);
        exp_x(64'h6000, 17'h00004, 1'b0);
        exp_pulse.push_back(2'b10);
        @(negedge CLK);
        start(64'h2005, 1'b0);
        wait_idle("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
